// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared widths, command codes and FSM encoding for the SPI front end
package spi_pkg;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_ADDRESS_SIZE = 8;
    localparam int DEF_READ_LATENCY = 1;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CMD   = 3'd1;
    localparam logic [2:0] S_ADDR  = 3'd2;
    localparam logic [2:0] S_WDATA = 3'd3;
    localparam logic [2:0] S_RWAIT = 3'd4;
    localparam logic [2:0] S_RDATA = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_CMD   = S_CMD,
        ST_ADDR  = S_ADDR,
        ST_WDATA = S_WDATA,
        ST_RWAIT = S_RWAIT,
        ST_RDATA = S_RDATA,
        ST_DONE  = S_DONE
    } state_t;

endpackage

// File: rtl/spi_shift_in.sv
// rtl/spi_shift_in.sv - serial-in parallel-out shift register with bit counter and done pulse
module spi_shift_in #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_value,
    output logic             o_done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] shift_q;
    logic [CW-1:0]    cnt_q;

    // o_value already includes the bit being sampled this edge, so the
    // parent can load the complete field on the same edge o_done is high.
    assign o_value = {shift_q[WIDTH-2:0], i_bit};
    assign o_done  = i_en && (cnt_q == CW'(WIDTH - 1));

    // Shift one bit per enabled edge; clear drops any partial field.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (i_clear) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (i_en) begin
            shift_q <= o_value;
            cnt_q   <= o_done ? '0 : cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/spi_frame_ctrl.sv
// rtl/spi_frame_ctrl.sv - SPI slave frame decoder driving reg_file writes and serialising reads
module spi_frame_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE,
    parameter int READ_LATENCY = DEF_READ_LATENCY
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_ss_n,
    input  logic                    i_mosi,
    input  logic [DATA_WIDTH-1:0]   i_rd_data,
    output logic [ADDRESS_SIZE-1:0] o_address,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_wr_en,
    output logic                    o_miso,
    output logic                    o_busy
);

    localparam int WW  = $clog2(READ_LATENCY + 1) + 1;
    localparam int RCW = $clog2(DATA_WIDTH + 1);

    state_t                  state_q;
    logic                    cmd_q;
    logic [WW-1:0]           wait_q;
    logic [DATA_WIDTH-1:0]   rd_shift_q;
    logic [RCW-1:0]          rd_cnt_q;

    logic [ADDRESS_SIZE-1:0] addr_value;
    logic                    addr_done;
    logic [DATA_WIDTH-1:0]   wdata_value;
    logic                    wdata_done;

    assign o_busy = (state_q != ST_IDLE);

    spi_shift_in #(.WIDTH(ADDRESS_SIZE)) u_addr_shift (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (state_q != ST_ADDR),
        .i_en    ((state_q == ST_ADDR) && !i_ss_n),
        .i_bit   (i_mosi),
        .o_value (addr_value),
        .o_done  (addr_done)
    );

    spi_shift_in #(.WIDTH(DATA_WIDTH)) u_wdata_shift (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (state_q != ST_WDATA),
        .i_en    ((state_q == ST_WDATA) && !i_ss_n),
        .i_bit   (i_mosi),
        .o_value (wdata_value),
        .o_done  (wdata_done)
    );

    // Frame FSM: slave-select high in any active state aborts on that edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            cmd_q      <= 1'b0;
            wait_q     <= '0;
            rd_shift_q <= '0;
            rd_cnt_q   <= '0;
            o_address  <= '0;
            o_data     <= '0;
            o_wr_en    <= 1'b0;
            o_miso     <= 1'b0;
        end else begin
            o_wr_en <= 1'b0;
            if (state_q != ST_IDLE && i_ss_n) begin
                state_q <= ST_IDLE;
                o_miso  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (!i_ss_n) state_q <= ST_CMD;
                    end
                    ST_CMD: begin
                        cmd_q   <= i_mosi;
                        state_q <= ST_ADDR;
                    end
                    ST_ADDR: begin
                        if (addr_done) begin
                            o_address <= addr_value;
                            if (cmd_q == CMD_WRITE) begin
                                state_q <= ST_WDATA;
                            end else begin
                                state_q <= ST_RWAIT;
                                wait_q  <= '0;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (wdata_done) begin
                            o_data  <= wdata_value;
                            o_wr_en <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                    ST_RWAIT: begin
                        if (wait_q == WW'(READ_LATENCY)) begin
                            rd_shift_q <= i_rd_data;
                            o_miso     <= i_rd_data[DATA_WIDTH-1];
                            rd_cnt_q   <= RCW'(1);
                            state_q    <= ST_RDATA;
                        end else begin
                            wait_q <= wait_q + WW'(1);
                        end
                    end
                    ST_RDATA: begin
                        if (rd_cnt_q == RCW'(DATA_WIDTH)) begin
                            o_miso  <= 1'b0;
                            state_q <= ST_DONE;
                        end else begin
                            o_miso     <= rd_shift_q[DATA_WIDTH-2];
                            rd_shift_q <= rd_shift_q << 1;
                            rd_cnt_q   <= rd_cnt_q + RCW'(1);
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_DONE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb/tb_spi_frame_ctrl.sv - scoreboard bench for spi_frame_ctrl with a reg_file model
module tb_spi_frame_ctrl;

    localparam int K_WR = 0;
    localparam int K_RD = 1;
    localparam int K_AB = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ss_n;
    logic       mosi;
    logic [7:0] rd_data;
    logic [7:0] address;
    logic [7:0] wdata;
    logic       wr_en;
    logic       miso;
    logic       busy;

    always #5 clk = ~clk;

    spi_frame_ctrl #(.DATA_WIDTH(8), .ADDRESS_SIZE(8), .READ_LATENCY(1)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_ss_n    (ss_n),
        .i_mosi    (mosi),
        .i_rd_data (rd_data),
        .o_address (address),
        .o_data    (wdata),
        .o_wr_en   (wr_en),
        .o_miso    (miso),
        .o_busy    (busy)
    );

    // reg_file stand-in: registered read, one cycle of latency
    logic [7:0] regmem [256];
    always @(posedge clk) begin
        if (wr_en) regmem[address] <= wdata;
        rd_data <= regmem[address];
    end

    typedef struct {
        int         kind;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] model [256];
    logic [7:0] written[$];
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic drive_bits(input logic [16:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            mosi = bits[i];
        end
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            mosi = 1'($urandom);
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        ss_n = 1'b0;
    endtask

    task automatic end_frame();
        @(negedge clk);
        ss_n = 1'b1;
        mosi = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int extra);
        exp_t e;
        e.kind = K_WR; e.addr = a; e.data = d;
        expq.push_back(e);
        model[a] = d;
        written.push_back(a);
        start_frame();
        drive_bits({1'b1, a, d}, 17);
        idle_bits(2 + extra);
        end_frame();
    endtask

    task automatic do_read(input logic [7:0] a);
        exp_t e;
        e.kind = K_RD; e.addr = a; e.data = model[a];
        expq.push_back(e);
        start_frame();
        drive_bits({8'h00, 1'b0, a}, 9);
        idle_bits(11);
        end_frame();
    endtask

    // Monitor: offsets are counted from the edge where o_busy first rises
    initial begin
        exp_t cur;
        int   k = 0;
        int   wr_seen = 0;
        bit   in_frame = 1'b0;
        cur.kind = K_AB; cur.addr = '0; cur.data = '0;
        forever begin
            @(negedge clk);
            if (busy && !in_frame) begin
                in_frame = 1'b1;
                k = 0;
                wr_seen = 0;
                if (expq.size() == 0) begin
                    chk("unexpected_frame", 32'd1, 32'd0);
                    cur.kind = K_AB;
                end else begin
                    cur = expq.pop_front();
                end
            end else if (busy && in_frame) begin
                k++;
            end
            if (in_frame && busy) begin
                if (wr_en) wr_seen++;
                case (cur.kind)
                    K_WR: begin
                        chk($sformatf("wr_en@k%0d", k), 32'(wr_en), 32'(k == 17));
                        if (k == 17) begin
                            chk("wr_address", 32'(address), 32'(cur.addr));
                            chk("wr_data", 32'(wdata), 32'(cur.data));
                        end
                        chk($sformatf("miso_idle@k%0d", k), 32'(miso), 32'd0);
                    end
                    K_RD: begin
                        if (k >= 11 && k <= 18)
                            chk($sformatf("miso_bit%0d_a%0h", 18 - k, cur.addr),
                                32'(miso), 32'(cur.data[18 - k]));
                        else
                            chk($sformatf("miso_idle@k%0d", k), 32'(miso), 32'd0);
                        chk("rd_no_wr_en", 32'(wr_en), 32'd0);
                    end
                    default: begin
                        chk("abort_no_wr_en", 32'(wr_en), 32'd0);
                        chk("abort_miso", 32'(miso), 32'd0);
                    end
                endcase
            end
            if (in_frame && !busy) begin
                if (cur.kind == K_WR) chk("wr_strobe_count", 32'(wr_seen), 32'd1);
                else chk("no_wr_strobe", 32'(wr_seen), 32'd0);
                in_frame = 1'b0;
            end
        end
    end

    initial begin
        exp_t e;
        logic [7:0] a;
        rst_n = 1'b0;
        ss_n  = 1'b1;
        mosi  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_address", 32'(address), 32'd0);
        chk("rst_data", 32'(wdata), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        do_write(8'h02, 8'h15, 0);
        do_write(8'hA6, 8'h99, 0);
        do_read(8'h02);
        do_write(8'hA6, 8'hFF, 0);
        do_read(8'hA6);

        // abort after four address bits
        e.kind = K_AB; e.addr = '0; e.data = '0;
        expq.push_back(e);
        start_frame();
        drive_bits({12'h000, 1'b1, 4'h1}, 5);
        @(negedge clk);
        ss_n = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        do_write(8'h10, 8'h3C, 0);

        // asynchronous reset after five write-data bits
        expq.push_back(e);
        start_frame();
        drive_bits({1'b1, 8'h02, 8'hE7} >> 3, 14);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_address", 32'(address), 32'd0);
        chk("async_rst_data", 32'(wdata), 32'd0);
        chk("async_rst_wr_en", 32'(wr_en), 32'd0);
        chk("async_rst_miso", 32'(miso), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        ss_n  = 1'b1;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        do_write(8'h33, 8'h5A, 0);
        do_read(8'h02);
        do_read(8'h10);

        // extra MOSI bits while held in DONE
        do_write(8'h44, 8'hC3, 10);
        do_read(8'h44);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 3))
                    0: a = 8'h02;
                    1: a = 8'hA6;
                    2: a = 8'h10;
                    default: a = 8'($urandom);
                endcase
                do_write(a, 8'($urandom), 0);
            end else begin
                a = written[$urandom_range(0, written.size() - 1)];
                do_read(a);
            end
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
- SPI-slave front end that sits directly upstream of reg_file.
- Deserialises MOSI frames into one-cycle reg_file write commands (address, data, write enable).
- For reads, presents the address to reg_file, captures the returned byte and shifts it out on MISO.
- The SPI bit clock is the system clock i_clk; MOSI and SS_n are sampled on the rising edge.

Parameters:
- DATA_WIDTH, 8, reg_file data width and read-data shift length.
- ADDRESS_SIZE, 8, reg_file address width and address shift length.
- READ_LATENCY, 1, i_clk cycles from o_address change (with o_wr_en low) to valid i_rd_data.

Ports:
- i_clk  input  1  system clock; all state changes on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_ss_n  input  1  SPI slave select, active low, frames a transaction.
- i_mosi  input  1  serial data in, MSB first.
- i_rd_data  input  DATA_WIDTH  reg_file o_data.
- o_address  output  ADDRESS_SIZE  reg_file address.
- o_data  output  DATA_WIDTH  reg_file write data.
- o_wr_en  output  1  one-cycle reg_file write strobe.
- o_miso  output  1  serial read data, MSB first.
- o_busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_address=0, o_data=0, o_wr_en=0, o_miso=0, o_busy=0; bit counter and shift registers cleared. A write in progress is discarded with no strobe.
- Frame format: 1 command bit (1=write, 0=read), then ADDRESS_SIZE address bits, then for writes DATA_WIDTH data bits. All fields MSB first.
- States: IDLE, CMD, ADDR, WDATA, RWAIT, RDATA, DONE.
- IDLE: i_ss_n sampled 0 -> CMD. MOSI is not sampled on this edge.
- CMD: sample i_mosi into the cmd flag -> ADDR, counter=0.
- ADDR: shift i_mosi into the address shift register for ADDRESS_SIZE edges. On the last edge:
  - load o_address;
  - write -> WDATA;
  - read -> RWAIT with wait counter=0.
- WDATA: shift DATA_WIDTH bits. On the last edge: load o_data, set o_wr_en=1 -> DONE. o_wr_en clears on the next edge, so it is exactly one cycle high. o_address and o_data are stable while the strobe is high.
- RWAIT: hold READ_LATENCY+1 edges with o_wr_en=0. On the final edge: capture i_rd_data into the shift register, o_miso=bit DATA_WIDTH-1 -> RDATA.
- RDATA: each edge shifts left; o_miso presents the next bit. After DATA_WIDTH bits have been presented -> DONE, o_miso=0.
- DONE: ignore i_mosi; stay until i_ss_n sampled 1 -> IDLE.
- Abort: i_ss_n sampled 1 in any non-IDLE state -> IDLE on that edge.
  - The sample on that edge is discarded.
  - No o_wr_en is issued and the partial shift contents are dropped.
  - o_address and o_data keep their last loaded values.
- Write timing (edge n = IDLE sees ss_n low): cmd at n+1, address at n+2..n+9, data at n+10..n+17. o_wr_en is high between n+17 and n+18.
- Read timing: address loaded at n+9. With READ_LATENCY=1, capture at n+11. o_miso carries bits 7..0 during cycles n+11..n+18.
- o_miso is 0 outside RDATA.
- o_data is updated only on write completion.

Decomposition:
- Shared package spi_pkg holds:
  - the state encoding localparams;
  - CMD_WRITE=1 and CMD_READ=0;
  - default widths, shared with reg_file and its bench.
- One natural sub-module: spi_shift_in, a width-parameterised serial-in/parallel-out shift register with a bit counter and a done pulse. It is instantiated for both the address and write-data fields.

Test Plan:
- Reset then write frame cmd=1, addr=0x02, data=0x15 -> o_wr_en high exactly one cycle at n+17 with o_address=0x02 and o_data=0x15; reg_file[0x02]=0x15.
- Write 0xA6<-0x99, then read frame cmd=0, addr=0x02 -> o_miso serialises 0x15 (00010101) MSB first on cycles n+11..n+18; o_wr_en never asserts.
- Overwrite 0xA6<-0xFF, then read 0xA6 -> MISO returns 0xFF, not 0x99.
- Write frame with i_ss_n raised after 4 address bits -> state returns to IDLE on that edge, no o_wr_en, o_busy=0. A following full write to 0x10<-0x3C then succeeds.
- Assert i_rst_n=0 mid-WDATA (after 5 data bits) -> all outputs are 0 immediately (asynchronously), no write strobe, next frame is decoded from CMD.
- Extra MOSI bits after a complete write while i_ss_n stays low -> held in DONE, no second o_wr_en. Raising i_ss_n returns to IDLE.
